// File: rtl/softmax_history_averager_pkg.sv
// Shared types and constants for the softmax history averager.
// Addresses come from the intermediate-result memory map.
package softmax_history_averager_pkg;

   typedef logic [15:0]        IntResAddr_t;
   typedef logic signed [14:0] IntResSingle_t;
   typedef logic signed [31:0] CompFx_t;
   typedef logic [1:0]         SoftmaxHistCnt_t;
   typedef logic [2:0]         SleepStage_t;

   localparam int IN_FRAC_BITS = 13;
   localparam int Q_COMP       = 21;
   localparam int N_CLASSES    = 5;

   localparam int MLP_HEAD_DENSE_2_OUT_MEM = 0;
   localparam int PREV_SOFTMAX_OUTPUT_MEM  = 1;

   localparam IntResAddr_t [1:0] mem_map = {16'd57334, 16'd32};

   // Q21 reciprocals of 1, 2 and 3 valid samples
   localparam logic [2:0][22:0] SOFTMAX_RECIP_Q21 =
      {23'd699051, 23'd1048576, 23'd2097152};

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_CUR,
      S_RD_H0,
      S_RD_H1,
      S_ACC,
      S_WR_H1,
      S_WR_H0,
      S_FIN
   } sm_state_t;

endpackage

// File: rtl/softmax_history_averager_avg_scaler.sv
// Combinational mask/sum/multiply/shift/saturate path
// producing one class average in IN_FRAC_BITS format.
module softmax_avg_scaler
   import softmax_history_averager_pkg::*;
(
   input  logic signed [14:0] cur,
   input  logic signed [14:0] h0,
   input  logic signed [14:0] h1,
   input  logic [1:0]         hist_cnt,
   output logic signed [14:0] avg
);

   localparam int SHIFT = Q_COMP - IN_FRAC_BITS;

   CompFx_t            c_x;
   CompFx_t            h0_x;
   CompFx_t            h1_x;
   CompFx_t            sum;
   logic [22:0]        rcp;
   logic signed [63:0] sum_w;
   logic signed [63:0] rcp_w;
   logic signed [63:0] prod;
   logic signed [63:0] avg_c;
   logic signed [63:0] res;

   always_comb begin
      c_x  = CompFx_t'(cur) <<< SHIFT;
      h0_x = '0;
      h1_x = '0;
      if (hist_cnt != 2'd0)
         h0_x = CompFx_t'(h0) <<< SHIFT;
      if (hist_cnt == 2'd2)
         h1_x = CompFx_t'(h1) <<< SHIFT;
      sum = c_x + h0_x + h1_x;

      case (hist_cnt)
         2'd0:    rcp = SOFTMAX_RECIP_Q21[0];
         2'd1:    rcp = SOFTMAX_RECIP_Q21[1];
         default: rcp = SOFTMAX_RECIP_Q21[2];
      endcase

      sum_w = 64'(sum);
      rcp_w = 64'(rcp);
      prod  = sum_w * rcp_w;
      // arithmetic shifts floor toward -inf
      avg_c = prod >>> Q_COMP;
      res   = avg_c >>> SHIFT;

      if (res > 64'sd16383)
         avg = 15'sd16383;
      else if (res < -64'sd16384)
         avg = -15'sd16384;
      else
         avg = res[14:0];
   end

endmodule

// File: rtl/softmax_history_averager.sv
// Averages current softmax with up to two previous samples,
// reports argmax stage, and shifts the history window.
module softmax_history_averager
   import softmax_history_averager_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        clear_hist,
   output logic        busy,
   output logic        done,
   output logic [2:0]  sleep_stage,
   output logic [14:0] avg_max,
   output logic        rd_en,
   output logic [15:0] rd_addr,
   input  logic [14:0] rd_data,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [14:0] wr_data
);

   localparam IntResAddr_t CUR_BASE  = mem_map[MLP_HEAD_DENSE_2_OUT_MEM];
   localparam IntResAddr_t HIST_BASE = mem_map[PREV_SOFTMAX_OUTPUT_MEM];
   localparam IntResAddr_t HIST_OLD  = HIST_BASE + 16'd5;

   sm_state_t       state;
   SoftmaxHistCnt_t hist_cnt;
   SleepStage_t     cls;
   SleepStage_t     best_idx;
   IntResSingle_t   best_val;
   IntResSingle_t   cur_q;
   IntResSingle_t   h0_q;
   IntResSingle_t   h1_q;
   IntResSingle_t   avg;
   IntResAddr_t     cls_a;

   assign busy  = (state != S_IDLE);
   assign cls_a = IntResAddr_t'(cls);

   softmax_avg_scaler u_scaler (
      .cur      (cur_q),
      .h0       (h0_q),
      .h1       (h1_q),
      .hist_cnt (hist_cnt),
      .avg      (avg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         hist_cnt    <= '0;
         cls         <= '0;
         best_idx    <= '0;
         best_val    <= '0;
         cur_q       <= '0;
         h0_q        <= '0;
         h1_q        <= '0;
         done        <= 1'b0;
         sleep_stage <= '0;
         avg_max     <= '0;
         rd_en       <= 1'b0;
         rd_addr     <= '0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (clear_hist)
                  hist_cnt <= '0;
               if (start) begin
                  state   <= S_RD_CUR;
                  cls     <= '0;
                  rd_en   <= 1'b1;
                  rd_addr <= CUR_BASE;
               end
            end
            S_RD_CUR: begin
               state   <= S_RD_H0;
               rd_addr <= HIST_BASE + cls_a;
            end
            S_RD_H0: begin
               cur_q   <= rd_data;
               state   <= S_RD_H1;
               rd_addr <= HIST_OLD + cls_a;
            end
            S_RD_H1: begin
               h0_q  <= rd_data;
               state <= S_ACC;
               rd_en <= 1'b0;
            end
            S_ACC: begin
               h1_q    <= rd_data;
               state   <= S_WR_H1;
               wr_en   <= 1'b1;
               wr_addr <= HIST_OLD + cls_a;
               wr_data <= h0_q;
            end
            S_WR_H1: begin
               state   <= S_WR_H0;
               wr_addr <= HIST_BASE + cls_a;
               wr_data <= cur_q;
            end
            S_WR_H0: begin
               wr_en <= 1'b0;
               // strict compare keeps the lowest index on ties
               if (cls == 3'd0 || avg > best_val) begin
                  best_idx <= cls;
                  best_val <= avg;
               end
               if (cls == 3'(N_CLASSES - 1)) begin
                  state <= S_FIN;
               end else begin
                  cls     <= cls + 3'd1;
                  state   <= S_RD_CUR;
                  rd_en   <= 1'b1;
                  rd_addr <= CUR_BASE + cls_a + 16'd1;
               end
            end
            S_FIN: begin
               sleep_stage <= best_idx;
               avg_max     <= best_val;
               done        <= 1'b1;
               if (hist_cnt != 2'd2)
                  hist_cnt <= hist_cnt + 2'd1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_softmax_history_averager.sv
// Directed bench for the softmax history averager
// with a behavioural intermediate-result memory.
module tb_softmax_history_averager;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        clear_hist;
   logic        busy;
   logic        done;
   logic [2:0]  sleep_stage;
   logic [14:0] avg_max;
   logic        rd_en;
   logic [15:0] rd_addr;
   logic [14:0] rd_data;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [14:0] wr_data;

   logic [14:0] mem [0:65535];
   int checks;
   int failures;
   int overlap;
   int rd_log[$];
   int wr_a[$];
   int wr_d[$];

   localparam int CUR  = 32;
   localparam int HIST = 57334;

   softmax_history_averager dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .clear_hist  (clear_hist),
      .busy        (busy),
      .done        (done),
      .sleep_stage (sleep_stage),
      .avg_max     (avg_max),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

   always @(negedge clk) begin
      if (rd_en && wr_en) overlap++;
      if (rd_en) rd_log.push_back(int'(rd_addr));
      if (wr_en) begin
         wr_a.push_back(int'(wr_addr));
         wr_d.push_back(int'($signed(wr_data)));
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_cur(input int a, b, c, d, e);
      mem[CUR+0] = 15'(a);
      mem[CUR+1] = 15'(b);
      mem[CUR+2] = 15'(c);
      mem[CUR+3] = 15'(d);
      mem[CUR+4] = 15'(e);
   endtask

   task automatic run(input string tag, input logic clr);
      int lat;
      @(negedge clk);
      start = 1'b1;
      clear_hist = clr;
      @(negedge clk);
      start = 1'b0;
      clear_hist = 1'b0;
      lat = 0;
      while (!done && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, lat, 31);
   endtask

   task automatic chk_out(input string tag, input int st, input int av);
      chk({tag, "_stage"}, int'(sleep_stage), st);
      chk({tag, "_avg"}, int'($signed(avg_max)), av);
   endtask

   initial begin
      int dn;
      int first;
      checks = 0;
      failures = 0;
      overlap = 0;
      rst_n = 1'b0;
      start = 1'b0;
      clear_hist = 1'b0;
      rd_data = '0;
      for (int i = 0; i < 10; i++) mem[HIST+i] = 15'(1000 + i);
      set_cur(819, 4915, 819, 819, 820);
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_stage", int'(sleep_stage), 0);
      chk("rst_avg", int'(avg_max), 0);
      rst_n = 1'b1;

      rd_log.delete();
      wr_a.delete();
      wr_d.delete();
      run("t1", 1'b0);
      chk_out("t1", 1, 4915);
      chk("t1_rd0", rd_log[0], 32);
      chk("t1_rd1", rd_log[1], 57334);
      chk("t1_rd2", rd_log[2], 57339);
      chk("t1_wa0", wr_a[0], 57339);
      chk("t1_wd0", wr_d[0], 1000);
      chk("t1_wa1", wr_a[1], 57334);
      chk("t1_wd1", wr_d[1], 819);
      chk("t1_mem_h1_4", int'(mem[HIST+9]), 1004);
      chk("t1_busy_after", int'(busy), 0);

      set_cur(8192, 0, 0, 0, 0);
      run("r1", 1'b1);
      chk_out("r1", 0, 8192);
      set_cur(0, 0, 0, 0, 0);
      run("r2", 1'b0);
      chk_out("r2", 0, 4096);
      set_cur(0, 0, 3000, 0, 0);
      mem[HIST+2] = 15'd3000;
      mem[HIST+7] = 15'd3000;
      run("r3", 1'b0);
      chk_out("r3", 2, 3000);
      chk("r3_mem_h0_0", int'(mem[HIST+0]), 0);
      chk("r3_mem_h1_2", int'(mem[HIST+7]), 3000);

      set_cur(1638, 1638, 1638, 1638, 1638);
      run("tie", 1'b1);
      chk_out("tie", 0, 1638);

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_done", int'(done), 0);
      chk("mrst_rd_en", int'(rd_en), 0);
      chk("mrst_wr_en", int'(wr_en), 0);
      chk("mrst_avg", int'(avg_max), 0);
      @(negedge clk);
      rst_n = 1'b1;
      set_cur(0, 0, 0, 4000, 0);
      run("postrst", 1'b0);
      chk_out("postrst", 3, 4000);

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dn = 0;
      first = -1;
      for (int k = 1; k <= 45; k++) begin
         if (k == 5) begin
            start = 1'b1;
            clear_hist = 1'b1;
         end else if (k == 6) begin
            start = 1'b0;
            clear_hist = 1'b0;
         end
         @(negedge clk);
         if (done) begin
            dn++;
            if (first < 0) first = k;
         end
      end
      chk("busyign_dones", dn, 1);
      chk("busyign_latency", first, 31);
      chk_out("busyign", 3, 4000);
      set_cur(0, 0, 0, 1000, 0);
      run("cnt2", 1'b0);
      chk_out("cnt2", 3, 3000);
      @(negedge clk);
      clear_hist = 1'b1;
      @(negedge clk);
      clear_hist = 1'b0;
      run("clr", 1'b0);
      chk_out("clr", 3, 1000);

      for (int i = 0; i < 10; i++) mem[HIST+i] = 15'h4000;
      set_cur(-16384, -16384, -16384, -16384, -16384);
      run("neg1", 1'b0);
      chk_out("neg1", 0, -16384);
      run("neg2", 1'b0);
      chk_out("neg2", 0, -16384);

      chk("no_rd_wr_overlap", overlap, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
